// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its word array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int XLEN_DEF = 32;
  localparam int STRB_W   = XLEN_DEF / 8;

  // Replace the strobed bytes of old_word with the matching bytes of new_word.
  function automatic logic [XLEN_DEF-1:0] byte_merge(
    input logic [XLEN_DEF-1:0] old_word,
    input logic [XLEN_DEF-1:0] new_word,
    input logic [STRB_W-1:0]   strb
  );
    logic [XLEN_DEF-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port byte-writable word array; read data follows idx combinationally.
module dmem_sram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [XLEN/8-1:0] be,
  input  logic [AW-1:0]     idx,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  assign rdata = mem[idx];

  // Byte-lane write of the enabled lanes at idx.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: accepts one request, waits LATENCY cycles, commits and
// returns the post-merge word (or an error) as a one-cycle pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_v,
  input  logic              w_v,
  input  logic [XLEN-1:0]   data_adr,
  input  logic [XLEN-1:0]   data_i,
  input  logic [STRB_W-1:0] strobe,
  output logic [XLEN-1:0]   dmem_resp,
  output logic              dmem_resp_v,
  output logic              err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic accept, commit;

  // Request captured at accept
  logic [XLEN-1:0]   adr_reg, wdata_reg;
  logic [STRB_W-1:0] strb_reg;
  logic              write_reg, both_reg;

  // Operands seen by the array: live inputs while idle (needed when
  // LATENCY==1 commits on the accept edge), captured values afterwards.
  logic              live;
  logic [XLEN-1:0]   cur_adr, cur_wdata;
  logic [STRB_W-1:0] cur_strb;
  logic              cur_write, cur_both, out_of_range;
  logic [XLEN-1:0]   rdata, merged;
  logic              we;
  logic              unused_bits;

  assign live      = (state_reg == IDLE);
  assign cur_adr   = live ? data_adr : adr_reg;
  assign cur_wdata = live ? data_i : wdata_reg;
  assign cur_strb  = live ? strobe : strb_reg;
  assign cur_write = live ? w_v : write_reg;
  assign cur_both  = live ? (r_v & w_v) : both_reg;

  assign out_of_range = |cur_adr[XLEN-1:AW+2];
  assign unused_bits  = &{1'b0, cur_adr[1:0]};

  assign merged = byte_merge(rdata, cur_wdata, cur_write ? cur_strb : '0);
  // Reset on the commit edge must also suppress the array write.
  assign we     = commit & rst_n & cur_write & ~out_of_range;
  assign busy   = (state_reg != IDLE);

  dmem_sram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .we    (we),
    .be    (cur_strb),
    .idx   (cur_adr[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (rdata)
  );

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; commit marks the edge that enters RESP.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (r_v | w_v) begin
          accept   = 1'b1;
          cnt_next = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request on accept; write wins when both valids are high.
  always_ff @(posedge clk) begin
    if (accept) begin
      adr_reg   <= data_adr;
      wdata_reg <= data_i;
      strb_reg  <= strobe;
      write_reg <= w_v;
      both_reg  <= r_v & w_v;
    end
  end

  // Response registers: pulse on commit, data held until the next response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_resp   <= '0;
      dmem_resp_v <= 1'b0;
      err         <= 1'b0;
    end else begin
      dmem_resp_v <= commit;
      err         <= commit & (out_of_range | cur_both);
      if (commit) dmem_resp <= out_of_range ? '0 : merged;
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave on the far end of the core's dmem request interface (r_v/w_v, data_adr, data_o, strobe → dmem_resp, dmem_resp_v).
- Accepts one request at a time into a byte-strobed word array and returns read data, or a write acknowledge, after a programmable latency.
- Sits beside the CPU in the SoC top and gives simulation and FPGA builds a cycle-deterministic data memory.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 1024, number of XLEN-bit words; power of two.
- LATENCY, 2, cycles from request accept to dmem_resp_v; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- r_v  in  1  read request valid.
- w_v  in  1  write request valid.
- data_adr  in  XLEN  byte address; word index = data_adr[log2(DEPTH)+1:2].
- data_i  in  XLEN  write data; the core's data_o connects here.
- strobe  in  4  byte enables for writes; bit n covers bits [8n+7:8n].
- dmem_resp  out  XLEN  read data, or post-write word on writes.
- dmem_resp_v  out  1  one-cycle response pulse.
- err  out  1  valid only when dmem_resp_v=1; flags an out-of-range address or r_v&w_v.
- busy  out  1  high in WAIT and RESP.

Behaviour:
- Reset: all outputs are 0 and state is IDLE. Array contents are not reset.
- Reset asserted mid-operation returns the block to IDLE next edge with no response. An uncommitted write is dropped.
- FSM states IDLE, WAIT, RESP (encoded in dmem_pkg).
- IDLE:
  - If r_v|w_v, accept. Capture address, data_i, strobe, and the op (write if w_v, so write wins when both are high).
  - Load cnt = LATENCY-1.
  - Go to RESP if LATENCY==1, else WAIT.
- WAIT: cnt decrements each cycle. On the edge where cnt==1, go to RESP.
- Commit: on the edge entering RESP:
  - Writes update the enabled bytes of the word.
  - dmem_resp is registered with the word value after the merge. For reads this is the unmodified word.
- Timing: for accept at cycle t, dmem_resp_v=1 in cycle t+LATENCY.
- RESP: dmem_resp_v=1 for exactly one cycle, then IDLE. dmem_resp holds its value until the next response; dmem_resp_v and err drop to 0.
- Inputs during WAIT/RESP are ignored. The master holds its request until dmem_resp_v and may issue a new request the cycle after.
- Throughput is one request per LATENCY+1 cycles.
- Out-of-range: data_adr >= DEPTH*4 means the write is not performed, dmem_resp=0, err=1.
- r_v&w_v: treated as a write; err=1 with the response.
- Read strobe is ignored. A write with strobe=0 leaves the array unchanged and is still acknowledged.
- Low address bits [1:0] are ignored; all accesses are word-aligned.
- cnt is a 4-bit counter and never wraps, because it is reloaded on every accept.

Decomposition:
- dmem_pkg:
  - state_t enum {IDLE, WAIT, RESP}.
  - XLEN_DEF=32.
  - STRB_W=XLEN/8.
  - function byte_merge(old, new, strobe).
- Sub-module dmem_sram:
  - Single-port word array.
  - Inputs: we, byte-enable, idx, wdata.
  - rdata is combinational from idx.
  - Reused later by the imem side.
- The FSM, counter and error logic stay in dmem_responder.

Test Plan:
- LATENCY=2. Write adr=0x10, data=0xDEADBEEF, strobe=0xF at t0 → dmem_resp_v at t2, dmem_resp=0xDEADBEEF, err=0. Then read 0x10 at t3 → dmem_resp_v at t5 with 0xDEADBEEF.
- Partial write: strobe=0x2, data=0x0000AA00 to 0x10 → dmem_resp=0xDEADAAEF. Subsequent read returns 0xDEADAAEF.
- Request held high for 4 cycles with LATENCY=2 → exactly one dmem_resp_v pulse. A new read presented the cycle after the response is accepted.
- Read adr=0x1000 with DEPTH=1024 → dmem_resp=0, err=1. Write to 0x1000 → no array change; read-back of 0x0 is unchanged.
- r_v=w_v=1, adr=0x20, data=0x12345678, strobe=0xF → write performed, err=1. Then a read of 0x20 returns 0x12345678 with err=0.
- rst_n=0 for 1 cycle during WAIT of a write to 0x30 → no dmem_resp_v. busy=0 the next cycle. Read of 0x30 returns the old value.
